iter_alu: RTL and testbench

ITER_ALU -- requirements
Module: iter_alu

---
 rtl/iter_alu.sv | 234 +++++++++++++++++++++++
 tb/tb_iter_alu.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/iter_alu.sv
// iter_alu: iterative ALU. Single-cycle logic/arith/shift ops finish in one
// cycle; MULTU (shift-add) and DIVU (restoring) retire one bit per cycle.
// Build option: define ITER_ALU_DIV_EN to include the divider and DIV state;
// without it, opcode 1100 is reported as an invalid operation.
module iter_alu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] arg1,
  input  logic [WIDTH-1:0] arg2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             err
);

  localparam int unsigned ShW = $clog2(WIDTH);
  localparam logic [ShW-1:0] CntLast = ShW'(WIDTH - 1);

  localparam logic [3:0] OpAddu  = 4'b0000;
  localparam logic [3:0] OpSubu  = 4'b0001;
  localparam logic [3:0] OpAnd   = 4'b0010;
  localparam logic [3:0] OpOr    = 4'b0011;
  localparam logic [3:0] OpSlt   = 4'b0100;
  localparam logic [3:0] OpSltu  = 4'b0101;
  localparam logic [3:0] OpXor   = 4'b0110;
  localparam logic [3:0] OpNor   = 4'b0111;
  localparam logic [3:0] OpSll   = 4'b1000;
  localparam logic [3:0] OpSrl   = 4'b1001;
  localparam logic [3:0] OpSra   = 4'b1010;
  localparam logic [3:0] OpMultu = 4'b1011;
  localparam logic [3:0] OpDivu  = 4'b1100;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StDiv
  } state_e;

  state_e           state_q, state_d;
  logic [ShW-1:0]   cnt_q, cnt_d;
  // acc: product high half / partial remainder
  logic [WIDTH-1:0] acc_q, acc_d;
  // lo: multiplier shifting out / dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] lo_q, lo_d;
  // opnd: multiplicand / divisor captured at start
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] result_hi_q, result_hi_d;
  logic             zero_q, zero_d;
  logic             err_q, err_d;

  logic [ShW-1:0]   shamt;
  logic [WIDTH-1:0] sc_res;
  logic [WIDTH-1:0] sc_hi;
  logic             sc_err;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_nxt;
  logic [WIDTH-1:0] mul_lo_nxt;

`ifdef ITER_ALU_DIV_EN
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem_nxt;
  logic [WIDTH-1:0] div_quo_nxt;
`endif

  assign shamt = arg2[ShW-1:0];

  // Single-cycle results, plus the immediate outcomes of DIVU-by-zero and invalid codes
  always_comb begin
    sc_res = '0;
    sc_hi  = '0;
    sc_err = 1'b0;
    case (alu_ctrl)
      OpAddu:  sc_res = arg1 + arg2;
      OpSubu:  sc_res = arg1 - arg2;
      OpAnd:   sc_res = arg1 & arg2;
      OpOr:    sc_res = arg1 | arg2;
      OpSlt:   sc_res = {{(WIDTH-1){1'b0}}, ($signed(arg1) < $signed(arg2))};
      OpSltu:  sc_res = {{(WIDTH-1){1'b0}}, (arg1 < arg2)};
      OpXor:   sc_res = arg1 ^ arg2;
      OpNor:   sc_res = ~(arg1 | arg2);
      OpSll:   sc_res = arg1 << shamt;
      OpSrl:   sc_res = arg1 >> shamt;
      OpSra:   sc_res = WIDTH'($signed(arg1) >>> shamt);
      OpMultu: sc_res = '0;  // multi-cycle, never retired from here
`ifdef ITER_ALU_DIV_EN
      OpDivu: begin
        // Only reached for a zero divisor; nonzero divisors go to the DIV state
        sc_res = '1;
        sc_hi  = arg1;
        sc_err = 1'b1;
      end
`endif
      default: sc_err = 1'b1;
    endcase
  end

  // Shift-add multiplier step: add multiplicand if the current LSB is set, then shift right
  always_comb begin
    mul_sum    = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    mul_hi_nxt = mul_sum[WIDTH:1];
    mul_lo_nxt = {mul_sum[0], lo_q[WIDTH-1:1]};
  end

`ifdef ITER_ALU_DIV_EN
  // Restoring divider step: shift in next dividend bit, subtract if it fits
  always_comb begin
    div_shift   = {acc_q, lo_q[WIDTH-1]};
    div_diff    = div_shift - {1'b0, opnd_q};
    div_ge      = ~div_diff[WIDTH];
    div_rem_nxt = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    div_quo_nxt = {lo_q[WIDTH-2:0], div_ge};
  end
`endif

  // FSM next-state and datapath/result updates
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    lo_d        = lo_q;
    opnd_d      = opnd_q;
    done_d      = 1'b0;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    zero_d      = zero_q;
    err_d       = err_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (alu_ctrl == OpMultu) begin
            state_d = StMul;
            cnt_d   = '0;
            acc_d   = '0;
            lo_d    = arg1;
            opnd_d  = arg2;
`ifdef ITER_ALU_DIV_EN
          end else if (alu_ctrl == OpDivu && arg2 != '0) begin
            state_d = StDiv;
            cnt_d   = '0;
            acc_d   = '0;
            lo_d    = arg1;
            opnd_d  = arg2;
`endif
          end else begin
            done_d      = 1'b1;
            result_d    = sc_res;
            result_hi_d = sc_hi;
            zero_d      = (sc_res == '0);
            err_d       = sc_err;
          end
        end
      end

      StMul: begin
        acc_d = mul_hi_nxt;
        lo_d  = mul_lo_nxt;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          state_d     = StIdle;
          done_d      = 1'b1;
          result_d    = mul_lo_nxt;
          result_hi_d = mul_hi_nxt;
          zero_d      = (mul_lo_nxt == '0);
          err_d       = 1'b0;
        end
      end

`ifdef ITER_ALU_DIV_EN
      StDiv: begin
        acc_d = div_rem_nxt;
        lo_d  = div_quo_nxt;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          state_d     = StIdle;
          done_d      = 1'b1;
          result_d    = div_quo_nxt;
          result_hi_d = div_rem_nxt;
          zero_d      = (div_quo_nxt == '0);
          err_d       = 1'b0;
        end
      end
`endif

      default: state_d = StIdle;
    endcase
  end

  // State and result registers; reset aborts any running operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      acc_q       <= '0;
      lo_q        <= '0;
      opnd_q      <= '0;
      done_q      <= 1'b0;
      result_q    <= '0;
      result_hi_q <= '0;
      zero_q      <= 1'b1;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      lo_q        <= lo_d;
      opnd_q      <= opnd_d;
      done_q      <= done_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      zero_q      <= zero_d;
      err_q       <= err_d;
    end
  end

  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign zero      = zero_q;
  assign err       = err_q;

endmodule

// File: tb/tb_iter_alu.sv
// Self-checking bench for iter_alu (WIDTH=32): scoreboard of expected results
// with the cycle in which done must appear; a monitor pops on each done.
module tb_iter_alu;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [3:0]   alu_ctrl;
  logic [W-1:0] arg1;
  logic [W-1:0] arg2;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic [W-1:0] result_hi;
  logic         zero;
  logic         err;

  iter_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .alu_ctrl  (alu_ctrl),
    .arg1      (arg1),
    .arg2      (arg2),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .result_hi (result_hi),
    .zero      (zero),
    .err       (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         err;
    int           due;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] last_res;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference model: expected outcome and latency of one operation
  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input int n);
    exp_t         e;
    logic [63:0]  prod;
    int           lat;
    e.res = '0;
    e.hi  = '0;
    e.err = 1'b0;
    lat   = 1;
    case (op)
      4'd0:  e.res = a + b;
      4'd1:  e.res = a - b;
      4'd2:  e.res = a & b;
      4'd3:  e.res = a | b;
      4'd4:  e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd5:  e.res = (a < b) ? 32'd1 : 32'd0;
      4'd6:  e.res = a ^ b;
      4'd7:  e.res = ~(a | b);
      4'd8:  e.res = a << b[4:0];
      4'd9:  e.res = a >> b[4:0];
      4'd10: e.res = $signed(a) >>> b[4:0];
      4'd11: begin
        prod  = {32'd0, a} * {32'd0, b};
        e.res = prod[31:0];
        e.hi  = prod[63:32];
        lat   = W + 1;
      end
`ifdef ITER_ALU_DIV_EN
      4'd12: begin
        if (b == 0) begin
          e.res = '1;
          e.hi  = a;
          e.err = 1'b1;
        end else begin
          e.res = a / b;
          e.hi  = a % b;
          lat   = W + 1;
        end
      end
`endif
      default: e.err = 1'b1;
    endcase
    e.due = n + lat;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one start cycle and record the expected outcome; operands are
  // scrambled afterwards since the DUT must have captured them
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    start    = 1'b1;
    alu_ctrl = op;
    arg1     = a;
    arg2     = b;
    sb.push_back(model(op, a, b, cyc));
    tick();
    start = 1'b0;
    arg1  = $urandom;
    arg2  = $urandom;
  endtask

  task automatic wait_drain(input int max_cycles);
    int n = 0;
    while (sb.size() != 0 && n < max_cycles) begin
      tick();
      n++;
    end
    check("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  // Compare every done pulse against the head of the scoreboard
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_done", 64'(done), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("done_cycle", 64'(cyc), 64'(e.due));
        check("result", 64'(result), 64'(e.res));
        check("result_hi", 64'(result_hi), 64'(e.hi));
        check("zero", 64'(zero), 64'(e.res == '0));
        check("err", 64'(err), 64'(e.err));
        last_res = e.res;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int dcount;
    rst_n    = 1'b0;
    start    = 1'b0;
    alu_ctrl = '0;
    arg1     = '0;
    arg2     = '0;
    tick();
    tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_result_hi", 64'(result_hi), 64'd0);
    check("rst_zero", 64'(zero), 64'd1);
    check("rst_err", 64'(err), 64'd0);
    rst_n = 1'b1;

    // Idle after reset: done never pulses, outputs stay at reset values
    dcount = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done) dcount++;
    end
    check("idle_done_count", 64'(dcount), 64'd0);
    check("idle_result", 64'(result), 64'd0);
    check("idle_zero", 64'(zero), 64'd1);

    // Wrap, signed/unsigned compare, arithmetic shift with ignored upper bits
    issue(4'd0, 32'hFFFF_FFFF, 32'd1);
    issue(4'd4, 32'hFFFF_FFFF, 32'd1);
    issue(4'd5, 32'hFFFF_FFFF, 32'd1);
    issue(4'd10, 32'h8000_0000, 32'h24);
    wait_drain(10);
    check("sra_spec", 64'(result), 64'h0000_0000_F800_0000);

    // MULTU with a start pulse while busy that must be ignored
    issue(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    n0 = cyc - 1;
    check("mul_busy_first", 64'(busy), 64'd1);
    while (cyc < n0 + 5) tick();
    start    = 1'b1;
    alu_ctrl = 4'd0;
    arg1     = 32'd1;
    arg2     = 32'd1;
    tick();
    start = 1'b0;
    while (cyc < n0 + 32) tick();
    check("mul_busy_last", 64'(busy), 64'd1);
    tick();
    check("mul_busy_end", 64'(busy), 64'd0);
    check("mul_done_end", 64'(done), 64'd1);
    wait_drain(5);
    check("mul_hi_spec", 64'(result_hi), 64'h0000_0000_FFFF_FFFE);

    // Divide (or invalid code 1100 when the divider is not built)
    issue(4'd12, 32'd100, 32'd7);
    wait_drain(40);
    issue(4'd12, 32'd5, 32'd0);
    wait_drain(40);

    // Invalid codes
    issue(4'd13, 32'h1234, 32'h5678);
    issue(4'd15, 32'hFFFF, 32'd0);
    wait_drain(5);

    // Back-to-back: single-cycle then MULTU started in the done cycle
    issue(4'd0, 32'd3, 32'd4);
    issue(4'd11, 32'd6, 32'd7);
    wait_drain(40);

    // Results hold after done
    repeat (3) tick();
    check("hold_result", 64'(result), 64'(last_res));

    // Reset in the middle of MULTU aborts it; next op runs normally
    issue(4'd11, 32'd123, 32'd456);
    n0 = cyc - 1;
    while (cyc < n0 + 10) tick();
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_result", 64'(result), 64'd0);
    check("abort_zero", 64'(zero), 64'd1);
    while (cyc < n0 + 12) tick();
    rst_n = 1'b1;
    tick();
    issue(4'd2, 32'hF0, 32'h3C);
    wait_drain(5);
    check("and_after_abort", 64'(result), 64'h30);
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) dcount++;
    end
    check("no_late_done", 64'(dcount), 64'd0);

    // Random operations
    for (int i = 0; i < 40; i++) begin
      logic [3:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = (i % 5 == 0) ? W'($urandom_range(0, 40)) : $urandom;
      issue(op, a, b);
      wait_drain(40);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
